// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: source selects, load
// encodings, FSM state type and the context captured for a pending load.
package wb_stage_pkg;

  // Writeback source select
  typedef enum logic [1:0] {
    WB_LOAD = 2'b00,
    WB_ALU  = 2'b01,
    WB_PC   = 2'b10,
    WB_IMM  = 2'b11
  } wbsel_e;

  // Load type (funct3); any other value behaves as LW
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } wb_state_e;

  // What a pending load still needs once the memory word arrives
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] offset;
    logic       wr_en;   // reg_wr && rd != 0, resolved at accept time
  } load_ctx_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational byte/half/word extraction with sign or zero
// extension, plus misalignment detection for halves and words.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] word,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] data,
  output logic              misalign
);

  logic [31:0] lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Sub-word lanes always come from the low 32 bits of the memory word
  assign lo       = word[31:0];
  assign byte_sel = lo[{offset, 3'b000} +: 8];
  assign half_sel = lo[{offset[1], 4'b0000} +: 16];

  // Extract and extend by load type; unknown encodings fall to LW
  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(DWIDTH-8){1'b0}}, byte_sel};
      F3_LH: begin
        data     = {{(DWIDTH-16){half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      F3_LHU: begin
        data     = {{(DWIDTH-16){1'b0}}, half_sel};
        misalign = offset[0];
      end
      default: begin
        data     = word;
        misalign = |offset;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: register-file writeback. Non-load sources write one cycle after
// accept; loads park in WAIT_MEM until the memory word is valid.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data forwarding outputs.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        WBSel,
  input  logic [2:0]        funct3,
  input  logic [RWIDTH-1:0] rd,
  input  logic              reg_wr,
  input  logic [AWIDTH-1:0] alu_out,
  input  logic [AWIDTH-1:0] pc_updated,
  input  logic [DWIDTH-1:0] imm,
  input  logic [DWIDTH-1:0] DataR,
  input  logic              mem_rvalid,
  output logic              rf_we,
  output logic [RWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic              misalign
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RWIDTH-1:0] fwd_rd,
  output logic [DWIDTH-1:0] fwd_data
`endif
);

  wb_state_e         state;
  load_ctx_t         ld_ctx;
  logic [RWIDTH-1:0] ld_rd;
  logic              accept;
  logic              wr_ok;
  logic [DWIDTH-1:0] src_data;
  logic [DWIDTH-1:0] al_data;
  logic              al_mis;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign wr_ok    = reg_wr && (rd != '0);

  // Non-load source mux, zero-extended to the register width
  always_comb begin
    src_data = '0;
    case (WBSel)
      WB_ALU:  src_data = DWIDTH'(alu_out);
      WB_PC:   src_data = DWIDTH'(pc_updated);
      WB_IMM:  src_data = imm;
      default: src_data = '0;
    endcase
  end

  load_align #(.DWIDTH(DWIDTH)) u_align (
    .word     (DataR),
    .offset   (ld_ctx.offset),
    .funct3   (ld_ctx.funct3),
    .data     (al_data),
    .misalign (al_mis)
  );

  // Writeback FSM; write port only updates on an actual write so the
  // address/data hold their last value between writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ld_ctx   <= '0;
      ld_rd    <= '0;
      rf_we    <= 1'b0;
      misalign <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (WBSel == WB_LOAD) begin
              ld_ctx <= '{funct3: funct3, offset: alu_out[1:0], wr_en: wr_ok};
              ld_rd  <= rd;
              state  <= S_WAIT_MEM;
            end else if (wr_ok) begin
              rf_we    <= 1'b1;
              rf_waddr <= rd;
              rf_wdata <= src_data;
            end
          end
        end
        S_WAIT_MEM: begin
          if (mem_rvalid) begin
            state <= S_IDLE;
            if (al_mis) begin
              misalign <= 1'b1;
            end else if (ld_ctx.wr_en) begin
              rf_we    <= 1'b1;
              rf_waddr <= ld_rd;
              rf_wdata <= al_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address/PC width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; multiple of 8 and at least 32.
REQ-003 SHALL have parameter RWIDTH, default 5, register-index width.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-005 SHALL have the following ports:
- in_valid  input  1  writeback request valid
- in_ready  output  1  stage can accept a request
- WBSel  input  2  source select: 00 load, 01 alu_out, 10 pc_updated, 11 imm
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd  input  RWIDTH  destination register
- reg_wr  input  1  instruction writes rd
- alu_out  input  AWIDTH  ALU result; also the load address
- pc_updated  input  AWIDTH  PC+4 for link
- imm  input  DWIDTH  immediate (LUI)
- DataR  input  DWIDTH  memory read word
- mem_rvalid  input  1  DataR valid
- rf_we  output  1  register-file write strobe
- rf_waddr  output  RWIDTH  write index
- rf_wdata  output  DWIDTH  write data
- misalign  output  1  one-cycle misaligned-load flag

Function
REQ-006 SHALL implement a two-state FSM: IDLE and WAIT_MEM.
REQ-007 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid and in_ready are both 1.
REQ-008 Non-load request (WBSel!=00) accepted in cycle N SHALL pulse rf_we in cycle N+1 for exactly one cycle, with the selected source, zero-extended to DWIDTH, on rf_wdata.
REQ-009 Load request (WBSel=00) SHALL latch rd, funct3 and alu_out[1:0], then move to WAIT_MEM.
REQ-010 In WAIT_MEM, the first cycle M with mem_rvalid=1 SHALL produce rf_we at M+1 and return to IDLE at M+1; in_ready stays 0 through cycle M.
REQ-011 SHALL ignore mem_rvalid in IDLE and in the accepting cycle.
REQ-012 Load extraction SHALL work as follows:
- LB/LBU select the byte at alu_out[1:0].
- LH/LHU select the half-word at alu_out[1].
- LW passes the word.
- LB/LH sign-extend; LBU/LHU zero-extend to DWIDTH.
REQ-013 LH/LHU with alu_out[0]=1, or LW with alu_out[1:0]!=0, SHALL suppress rf_we and pulse misalign in the cycle the write would have occurred.
REQ-014 Undefined funct3 values on a load SHALL be treated as LW.
REQ-015 SHALL suppress rf_we when rd=0 or reg_wr=0; latency and the FSM are unchanged.
REQ-016 rf_waddr and rf_wdata SHALL be registered and hold their last value when rf_we=0.

Reset
REQ-017 While rst_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- drive rf_we=0, misalign=0, rf_waddr=0, rf_wdata=0;
- drive in_ready=1 from the first cycle after reset is released.
REQ-018 Reset in WAIT_MEM SHALL abandon the pending load with no write; a later mem_rvalid is ignored.

Configuration
REQ-019 With macro WB_FWD_EN defined, the block SHALL add these outputs, mirroring rf_we, rf_waddr and rf_wdata for operand forwarding:
- fwd_valid  output  1
- fwd_rd  output  RWIDTH
- fwd_data  output  DWIDTH
REQ-020 Without WB_FWD_EN, these ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package SHALL hold the WBSel encodings, the funct3 load encodings and the FSM state type.
REQ-022 Load extraction SHALL be a combinational sub-module load_align (inputs: word, offset, funct3; outputs: data, misalign).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ALU request: WBSel=01, alu_out=0x12345678, rd=5, reg_wr=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678.
- Signed byte load: LB, alu_out[1:0]=3, DataR=0x80FF0000, mem_rvalid 3 cycles after accept -> rf_wdata=0xFFFFFF80, one cycle after mem_rvalid; in_ready=0 throughout.
- Unsigned half load: LHU, alu_out[1:0]=2, DataR=0xBEEF1234 -> rf_wdata=0x0000BEEF.
- Misaligned word load: LW, alu_out[1:0]=1 -> rf_we=0, misalign=1 for one cycle.
- Write to x0: WBSel=11, imm=0xABCDE000, rd=0 -> rf_we=0; then reset asserted in WAIT_MEM followed by mem_rvalid -> no write, in_ready=1.
- Forwarding: with WB_FWD_EN defined, fwd_data equals rf_wdata every cycle in all of the scenarios above.
